// File: rtl/branch_resolve.sv
// branch_resolve: resolves branch direction and target from a decoded branch
// op and the registered compare result, checks it against the fetch-time
// static prediction, and on a mispredict pulses flush and holds a PC redirect
// toward fetch until it is accepted. Also keeps saturating branch statistics.
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   br_valid / br_ready         branch op handshake from decode
//   br_pc, br_imm, br_funct3    branch PC, sign-extended B-type offset, type
//   br_pred_taken               static prediction used by fetch
//   cond_in                     compare result, valid the cycle after accept
//   res_valid/taken/target/illegal  one-cycle resolution result
//   flush                       one-cycle pulse on mispredict
//   redir_valid / redir_ready   PC redirect handshake toward fetch
//   redir_pc                    redirect address, stable while pending
//   stat_branches, stat_mispred saturating statistics counters
module branch_resolve #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [2:0]       br_funct3,
    input  logic             br_pred_taken,
    input  logic             cond_in,
    output logic             res_valid,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic             res_illegal,
    output logic             flush,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EVAL     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state, state_nxt;
    logic [XLEN-1:0]  pc_q, pc_nxt;
    logic [XLEN-1:0]  imm_q, imm_nxt;
    logic [2:0]       funct3_q, funct3_nxt;
    logic             pred_q, pred_nxt;

    logic             br_ready_nxt;
    logic             res_valid_nxt, res_taken_nxt, res_illegal_nxt;
    logic [XLEN-1:0]  res_target_nxt;
    logic             flush_nxt, redir_valid_nxt;
    logic [XLEN-1:0]  redir_pc_nxt;
    logic [CNT_W-1:0] stat_branches_nxt, stat_mispred_nxt;

    logic             illegal_c, taken_c, mispred_c;
    logic [XLEN-1:0]  target_c;

    // Branch decision from the latched op and the compare result sampled in EVAL
    always_comb begin
        illegal_c = (funct3_q == 3'b010) || (funct3_q == 3'b011);
        taken_c   = cond_in && !illegal_c;
        target_c  = taken_c ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        mispred_c = (taken_c != pred_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc_q;
        imm_nxt           = imm_q;
        funct3_nxt        = funct3_q;
        pred_nxt          = pred_q;
        res_valid_nxt     = 1'b0;
        res_taken_nxt     = 1'b0;
        res_target_nxt    = '0;
        res_illegal_nxt   = 1'b0;
        flush_nxt         = 1'b0;
        redir_valid_nxt   = redir_valid;
        redir_pc_nxt      = redir_pc;
        stat_branches_nxt = stat_branches;
        stat_mispred_nxt  = stat_mispred;

        case (state)
            ST_IDLE: begin
                if (br_valid && br_ready) begin
                    pc_nxt     = br_pc;
                    imm_nxt    = br_imm;
                    funct3_nxt = br_funct3;
                    pred_nxt   = br_pred_taken;
                    state_nxt  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                res_valid_nxt   = 1'b1;
                res_taken_nxt   = taken_c;
                res_target_nxt  = target_c;
                res_illegal_nxt = illegal_c;
                if (stat_branches != CNT_MAX) begin
                    stat_branches_nxt = stat_branches + CNT_W'(1);
                end
                if (mispred_c) begin
                    if (stat_mispred != CNT_MAX) begin
                        stat_mispred_nxt = stat_mispred + CNT_W'(1);
                    end
                    flush_nxt       = 1'b1;
                    redir_valid_nxt = 1'b1;
                    redir_pc_nxt    = target_c;
                    state_nxt       = ST_REDIRECT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                // redir_pc is left untouched so it stays stable until accepted
                if (redir_ready) begin
                    redir_valid_nxt = 1'b0;
                    state_nxt       = ST_IDLE;
                end
            end
            default: begin
                redir_valid_nxt = 1'b0;
                state_nxt       = ST_IDLE;
            end
        endcase

        br_ready_nxt = (state_nxt == ST_IDLE);
    end

    // State and registered outputs; reset drops any pending redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc_q          <= '0;
            imm_q         <= '0;
            funct3_q      <= '0;
            pred_q        <= 1'b0;
            br_ready      <= 1'b1;
            res_valid     <= 1'b0;
            res_taken     <= 1'b0;
            res_target    <= '0;
            res_illegal   <= 1'b0;
            flush         <= 1'b0;
            redir_valid   <= 1'b0;
            redir_pc      <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            state         <= state_nxt;
            pc_q          <= pc_nxt;
            imm_q         <= imm_nxt;
            funct3_q      <= funct3_nxt;
            pred_q        <= pred_nxt;
            br_ready      <= br_ready_nxt;
            res_valid     <= res_valid_nxt;
            res_taken     <= res_taken_nxt;
            res_target    <= res_target_nxt;
            res_illegal   <= res_illegal_nxt;
            flush         <= flush_nxt;
            redir_valid   <= redir_valid_nxt;
            redir_pc      <= redir_pc_nxt;
            stat_branches <= stat_branches_nxt;
            stat_mispred  <= stat_mispred_nxt;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: randomized plus directed stimulus for branch_resolve with
// a queue-based scoreboard. The driver pushes expected results computed from
// the branch rules; a separate monitor pops and compares on res_valid and
// tracks the redirect handshake.
module tb_branch_resolve;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             br_valid;
    logic             br_ready;
    logic [XLEN-1:0]  br_pc;
    logic [XLEN-1:0]  br_imm;
    logic [2:0]       br_funct3;
    logic             br_pred_taken;
    logic             cond_in;
    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;
    logic             res_illegal;
    logic             flush;
    logic             redir_valid;
    logic             redir_ready;
    logic [XLEN-1:0]  redir_pc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_imm(br_imm), .br_funct3(br_funct3),
        .br_pred_taken(br_pred_taken), .cond_in(cond_in),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .res_illegal(res_illegal), .flush(flush),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic            illegal;
        logic            misp;
        logic [XLEN-1:0] target;
        int              nbr;
        int              nmis;
        int              due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rr_mode  = 0;      // 0: hold low, 1: hold high, 2: random
    int   m_br     = 0;
    int   m_mis    = 0;
    localparam int SAT = (1 << CNT_W) - 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fetch-side acceptance of redirects
    initial begin
        redir_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       redir_ready = 1'b0;
                1:       redir_ready = 1'b1;
                default: redir_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Offer one branch op, push its expected resolution, drive cond_in in EVAL.
    // Called and returns at a falling edge.
    task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input logic [2:0] f3, input logic pred, input logic cond);
        int   w;
        exp_t e;
        w             = 0;
        br_valid      = 1'b1;
        br_pc         = pc;
        br_imm        = imm;
        br_funct3     = f3;
        br_pred_taken = pred;
        cond_in       = ~cond;   // wrong value in the accept cycle
        while (!br_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!br_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout act=br_ready0 exp=br_ready1");
            br_valid = 1'b0;
            return;
        end
        e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
        e.taken   = e.illegal ? 1'b0 : cond;
        e.target  = e.taken ? pc + imm : pc + 32'd4;
        e.misp    = (e.taken != pred);
        m_br      = (m_br  >= SAT) ? SAT : m_br + 1;
        if (e.misp) m_mis = (m_mis >= SAT) ? SAT : m_mis + 1;
        e.nbr     = m_br;
        e.nmis    = m_mis;
        e.due     = cyc + 2;
        q.push_back(e);
        @(negedge clk);
        br_valid = 1'b0;
        cond_in  = cond;
        @(negedge clk);
        cond_in  = 1'($urandom_range(0, 1));
    endtask

    // Monitor / scoreboard
    initial begin
        bit              post_rst;
        bit              pend;
        bit              exp_idle;
        logic [XLEN-1:0] pend_pc;
        exp_t            e;
        post_rst = 1;
        pend     = 0;
        exp_idle = 0;
        pend_pc  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                q.delete();
                pend     = 0;
                exp_idle = 0;
                post_rst = 1;
                continue;
            end
            if (post_rst) begin
                post_rst = 0;
                chk("rst_br_ready",    64'(br_ready), 64'd1);
                chk("rst_res_valid",   64'(res_valid), 64'd0);
                chk("rst_res_taken",   64'(res_taken), 64'd0);
                chk("rst_res_target",  64'(res_target), 64'd0);
                chk("rst_res_illegal", 64'(res_illegal), 64'd0);
                chk("rst_flush",       64'(flush), 64'd0);
                chk("rst_redir_valid", 64'(redir_valid), 64'd0);
                chk("rst_redir_pc",    64'(redir_pc), 64'd0);
                chk("rst_stat_br",     64'(stat_branches), 64'd0);
                chk("rst_stat_mis",    64'(stat_mispred), 64'd0);
                continue;
            end
            if (exp_idle) begin
                chk("redir_done_valid", 64'(redir_valid), 64'd0);
                chk("redir_done_ready", 64'(br_ready), 64'd1);
                exp_idle = 0;
            end else if (pend) begin
                chk("redir_hold_valid", 64'(redir_valid), 64'd1);
                chk("redir_hold_pc",    64'(redir_pc), 64'(pend_pc));
                chk("redir_hold_ready", 64'(br_ready), 64'd0);
            end
            if (res_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_res act=res_valid1 exp=res_valid0 (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("res_latency",  64'(cyc), 64'(e.due));
                    chk("res_taken",    64'(res_taken), 64'(e.taken));
                    chk("res_target",   64'(res_target), 64'(e.target));
                    chk("res_illegal",  64'(res_illegal), 64'(e.illegal));
                    chk("flush",        64'(flush), 64'(e.misp));
                    chk("redir_valid",  64'(redir_valid), 64'(e.misp));
                    chk("br_ready_res", 64'(br_ready), 64'(!e.misp));
                    chk("stat_branches", 64'(stat_branches), 64'(e.nbr));
                    chk("stat_mispred",  64'(stat_mispred), 64'(e.nmis));
                    if (e.misp) begin
                        chk("redir_pc", 64'(redir_pc), 64'(e.target));
                        pend    = 1;
                        pend_pc = e.target;
                    end
                end
            end else begin
                chk("flush_idle", 64'(flush), 64'd0);
                if (!pend && !exp_idle) chk("redir_idle", 64'(redir_valid), 64'd0);
                if (q.size() > 0 && cyc > q[0].due) begin
                    checks++;
                    failures++;
                    $display("FAIL res_missing act=cyc%0d exp=cyc%0d", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
            if (pend && redir_ready) begin
                pend     = 0;
                exp_idle = 1;
            end
        end
    end

    // Main sequence
    initial begin
        logic [2:0] f3;
        logic       cnd;
        rst_n         = 1'b0;
        br_valid      = 1'b0;
        br_pc         = '0;
        br_imm        = '0;
        br_funct3     = '0;
        br_pred_taken = 1'b0;
        cond_in       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // taken BEQ, predicted not-taken, redirect accepted immediately
        rr_mode = 1;
        send(32'h100, 32'h20, 3'b000, 1'b0, 1'b1);
        // BNE backwards, correctly predicted taken
        send(32'h200, 32'hFFFF_FFF0, 3'b001, 1'b1, 1'b1);
        // not taken under taken prediction, fetch stalls the redirect
        rr_mode = 0;
        send(32'h300, 32'h40, 3'b000, 1'b1, 1'b0);
        fork
            send(32'h400, 32'h8, 3'b100, 1'b0, 1'b0);
            begin
                repeat (5) @(negedge clk);
                rr_mode = 1;
            end
        join
        // illegal funct3 values
        send(32'h500, 32'h10, 3'b010, 1'b0, 1'b1);
        send(32'h600, 32'h10, 3'b011, 1'b1, 1'b1);
        // PC wrap-around
        send(32'hFFFF_FFFC, 32'h8, 3'b101, 1'b1, 1'b1);
        // back-to-back mispredicts drive both counters into saturation
        for (int i = 0; i < 20; i++) begin
            cnd = 1'($urandom_range(0, 1));
            send($urandom, $urandom, 3'b110, ~cnd, cnd);
        end
        // reset while a redirect is pending
        rr_mode = 0;
        send(32'h700, 32'h100, 3'b111, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_br  = 0;
        m_mis = 0;

        // randomized traffic
        rr_mode = 2;
        for (int i = 0; i < 150; i++) begin
            f3  = 3'($urandom_range(0, 7));
            cnd = 1'($urandom_range(0, 1));
            send($urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64)),
                 f3, 1'($urandom_range(0, 1)), cnd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
